// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer with out-of-order completion,
// multi-slot commit and mispredict flush at retirement.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef MAX_NUM_OF_COMMITS
`define MAX_NUM_OF_COMMITS 2
`endif

module reorder_buffer #(
   parameter int ROB_DEPTH              = 16,
   parameter int PHYSICAL_REG_NUM_WIDTH = `PHYSICAL_REG_NUM_WIDTH,
   parameter int INST_ADDR_WIDTH        = `INST_ADDR_WIDTH,
   parameter int MAX_NUM_OF_COMMITS     = `MAX_NUM_OF_COMMITS,
   parameter int NUM_CDB                = 2,
   parameter int TAG_W                  = $clog2(ROB_DEPTH)
) (
   input  logic clk,
   input  logic reset,
   input  logic alloc_valid,
   input  logic alloc_reg_wb,
   input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_phy_wr_reg,
   output logic [TAG_W-1:0] alloc_tag,
   output logic rob_full,
   output logic [TAG_W:0] rob_count,
   output logic overflow_err,
   input  logic [NUM_CDB-1:0] complete_valid,
   input  logic [NUM_CDB-1:0][TAG_W-1:0] complete_tag,
   input  logic [NUM_CDB-1:0] complete_mispredict,
   input  logic [NUM_CDB-1:0][INST_ADDR_WIDTH-1:0] complete_target_pc,
   output logic [MAX_NUM_OF_COMMITS-1:0] commit_valid,
   output logic [MAX_NUM_OF_COMMITS-1:0] commit_with_write,
   output logic [MAX_NUM_OF_COMMITS-1:0][PHYSICAL_REG_NUM_WIDTH-1:0]
      commited_wr_register,
   output logic flush,
   output logic [INST_ADDR_WIDTH-1:0] flush_pc
);
   localparam int PW  = TAG_W + 1;
   localparam int MC  = MAX_NUM_OF_COMMITS;
   localparam int PRW = PHYSICAL_REG_NUM_WIDTH;
   localparam int IAW = INST_ADDR_WIDTH;

   logic [ROB_DEPTH-1:0] r_valid;
   logic [ROB_DEPTH-1:0] r_done;
   logic [ROB_DEPTH-1:0] r_misp;
   logic [ROB_DEPTH-1:0] r_wb;
   logic [PRW-1:0]       r_phy [ROB_DEPTH];
   logic [IAW-1:0]       r_tpc [ROB_DEPTH];
   logic [PW-1:0]        r_head;
   logic [PW-1:0]        r_tail;
   logic                 r_ovf;
   logic                 r_flush;
   logic [IAW-1:0]       r_flush_pc;
   logic [MC-1:0]        r_cv;
   logic [MC-1:0]        r_cw;
   logic [MC-1:0][PRW-1:0] r_cr;

   logic [PW-1:0]          w_count;
   logic [MC-1:0][TAG_W-1:0] w_idx;
   logic [MC-1:0]          w_ret;
   logic [PW-1:0]          w_nret;
   logic                   w_go;
   logic                   w_flush_now;
   logic [IAW-1:0]         w_flush_pc;
   logic                   w_alloc;
   logic                   w_ovf;
   logic [PW-1:0]          w_new_head;
   logic [TAG_W-1:0]       w_tail_idx;

   assign w_count    = r_tail - r_head;
   assign w_tail_idx = r_tail[TAG_W-1:0];

   // Retire a done prefix; a mispredicted entry ends the prefix.
   always_comb begin
      w_ret       = '0;
      w_nret      = '0;
      w_go        = 1'b1;
      w_flush_now = 1'b0;
      w_flush_pc  = '0;
      w_idx       = '0;
      for (int i = 0; i < MC; i++) begin
         w_idx[i] = r_head[TAG_W-1:0] + TAG_W'(i);
         if (w_go && r_valid[w_idx[i]] && r_done[w_idx[i]]) begin
            w_ret[i] = 1'b1;
            w_nret   = w_nret + PW'(1);
            if (r_misp[w_idx[i]]) begin
               w_flush_now = 1'b1;
               w_flush_pc  = r_tpc[w_idx[i]];
               w_go        = 1'b0;
            end
         end else begin
            w_go = 1'b0;
         end
      end
   end

   assign w_new_head = r_head + w_nret;
   assign w_alloc = alloc_valid && !r_flush && !w_flush_now &&
                    (w_count < PW'(ROB_DEPTH));
   assign w_ovf   = alloc_valid && !r_flush && !w_flush_now &&
                    (w_count == PW'(ROB_DEPTH));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_valid    <= '0;
         r_done     <= '0;
         r_misp     <= '0;
         r_wb       <= '0;
         r_ovf      <= 1'b0;
         r_flush    <= 1'b0;
         r_flush_pc <= '0;
         r_cv       <= '0;
         r_cw       <= '0;
         r_cr       <= '0;
         for (int k = 0; k < ROB_DEPTH; k++) begin
            r_phy[k] <= '0;
            r_tpc[k] <= '0;
         end
      end else begin
         r_head     <= w_new_head;
         r_flush    <= w_flush_now;
         r_flush_pc <= w_flush_now ? w_flush_pc : '0;
         r_cv       <= w_ret;
         for (int i = 0; i < MC; i++) begin
            r_cw[i] <= w_ret[i] & r_wb[w_idx[i]];
            r_cr[i] <= w_ret[i] ? r_phy[w_idx[i]] : '0;
         end
         if (w_ovf)
            r_ovf <= 1'b1;
         if (w_flush_now) begin
            r_valid <= '0;
            r_tail  <= w_new_head;
         end else begin
            // Descending order so the lowest port's target PC wins.
            for (int p = NUM_CDB - 1; p >= 0; p--) begin
               if (complete_valid[p] && r_valid[complete_tag[p]]) begin
                  r_done[complete_tag[p]] <= 1'b1;
                  if (complete_mispredict[p]) begin
                     r_misp[complete_tag[p]] <= 1'b1;
                     r_tpc[complete_tag[p]]  <= complete_target_pc[p];
                  end
               end
            end
            for (int i = 0; i < MC; i++) begin
               if (w_ret[i])
                  r_valid[w_idx[i]] <= 1'b0;
            end
            if (w_alloc) begin
               r_valid[w_tail_idx] <= 1'b1;
               r_done[w_tail_idx]  <= 1'b0;
               r_misp[w_tail_idx]  <= 1'b0;
               r_wb[w_tail_idx]    <= alloc_reg_wb;
               r_phy[w_tail_idx]   <= alloc_phy_wr_reg;
               r_tail              <= r_tail + PW'(1);
            end
         end
      end
   end

   assign alloc_tag            = w_tail_idx;
   assign rob_count            = w_count;
   assign rob_full             = w_count >= PW'(ROB_DEPTH - 1);
   assign overflow_err         = r_ovf;
   assign commit_valid         = r_cv;
   assign commit_with_write    = r_cw;
   assign commited_wr_register = r_cr;
   assign flush                = r_flush;
   assign flush_pc             = r_flush_pc;

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer between the decode/rename stage and the execution back end. It allocates one entry per renamed instruction, records out-of-order completions and retires up to `MAX_NUM_OF_COMMITS` entries per cycle in program order. It drives the commit interface that returns physical registers to the rename free list. A mispredicted branch generates the pipeline flush when it retires.

## Interface
- `ROB_DEPTH`, 16: number of entries; must be a power of two, ≥4.
- `PHYSICAL_REG_NUM_WIDTH`, `` `PHYSICAL_REG_NUM_WIDTH ``: width of physical register number.
- `INST_ADDR_WIDTH`, `` `INST_ADDR_WIDTH ``: PC width.
- `MAX_NUM_OF_COMMITS`, `` `MAX_NUM_OF_COMMITS ``: retire slots per cycle.
- `NUM_CDB`, 2: completion ports.
- `TAG_W`, $clog2(ROB_DEPTH): entry tag width (derived).

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low (asserted at 0).
- `alloc_valid` in 1: a renamed instruction is present this cycle.
- `alloc_reg_wb` in 1: the instruction writes a destination register.
- `alloc_phy_wr_reg` in PHYSICAL_REG_NUM_WIDTH: physical register to report at commit.
- `alloc_tag` out TAG_W: tag for the current allocation. Equals the tail index; combinational.
- `rob_full` out 1: stall request to decode.
- `rob_count` out TAG_W+1: occupied entries.
- `overflow_err` out 1: sticky flag, set when an allocation is dropped because the buffer is full.
- `complete_valid` in [NUM_CDB-1:0]: completion strobes.
- `complete_tag` in TAG_W [NUM_CDB-1:0]: tag of the completing entry.
- `complete_mispredict` in [NUM_CDB-1:0]: the completing branch was mispredicted.
- `complete_target_pc` in INST_ADDR_WIDTH [NUM_CDB-1:0]: correct PC when mispredicted.
- `commit_valid` out [MAX_NUM_OF_COMMITS-1:0]: retire strobes.
- `commit_with_write` out [MAX_NUM_OF_COMMITS-1:0]: the retired entry had `reg_wb`.
- `commited_wr_register` out PHYSICAL_REG_NUM_WIDTH [MAX_NUM_OF_COMMITS-1:0]: register reported per slot.
- `flush` out 1: one-cycle pipeline flush pulse.
- `flush_pc` out INST_ADDR_WIDTH: redirect PC, valid while `flush` is 1.

## Operation
- **Storage:** circular array. Each entry holds `valid`, `done`, `mispredict`, `reg_wb`, `phy_reg` and `target_pc`.
- **Pointers:** `head` and `tail` are TAG_W+1 bits wide; the MSB is the wrap bit. Count = tail − head, modulo 2^(TAG_W+1).
- **Allocation:**
  - Accepted when `alloc_valid`, count < ROB_DEPTH and `flush` is 0.
  - Writes the entry at `tail` with `valid`=1, `done`=0, `mispredict`=0, then increments `tail`.
  - If `alloc_valid` arrives with count == ROB_DEPTH, the allocation is dropped and `overflow_err` is set. It clears only on reset.
- **rob_full:** asserted when free entries < 2, i.e. count ≥ ROB_DEPTH−1. The extra entry absorbs the instruction already in decode's output register.
- **Completion:**
  - For each port with `complete_valid` and `valid[tag]`=1: set `done`; if mispredicted, set `mispredict` and store `target_pc`.
  - A completion to an invalid entry is ignored.
  - Two ports naming the same tag: flags are ORed; the target PC is taken from the lower port index.
- **Commit selection:**
  - Combinational, from registered entry state. Slot i (0..MAX−1) retires entry head+i.
  - Slot i retires only if entries head..head+i are all valid and done, and none of head..head+i−1 is mispredicted.
  - `head` advances by the number retired.
- **Commit outputs:** registered. Slot i drives `commit_valid[i]`, `commit_with_write[i]`=`reg_wb`, and `commited_wr_register[i]`=`phy_reg`. Unused slots drive 0.
- **Flush:**
  - Triggered when a retiring slot holds a mispredicted entry. That entry retires normally; later slots do not retire.
  - At the same edge: `flush`<=1, `flush_pc`<=`target_pc`, every `valid` is cleared, `tail`<=new head, count becomes 0.
  - Allocations and completions sampled at that edge are discarded.
  - `flush` returns to 0 on the next edge. Allocation resumes in the cycle after `flush` is high.
- **Simultaneous events:** allocation and retirement in the same cycle are both performed; next count = count + alloc − retired. Allocating into an entry freed in the same cycle is legal.

## Timing
- **Reset (`reset`=0):** `head`=`tail`=0, all entries invalid, and every output is 0 (`rob_full`, `rob_count`, `overflow_err`, `commit_*`, `flush`, `flush_pc`, `alloc_tag`).
- **Reset mid-operation:** reset applied at any point forces the same state immediately (asynchronous). No commits are emitted for discarded entries.
- **Allocation:** the entry is visible at the edge following `alloc_valid`. `rob_count` and `rob_full` update at that edge.
- **Completion to commit:** a completion sampled at edge E produces `commit_valid` high during the cycle after edge E+1. The entry's `done` bit is set at edge E, commit is selected in cycle E+1 and registered at E+1; latency is 2 edges when the entry is at the head.
- **Commit strobes:** each `commit_valid` bit is a single-cycle pulse per retired entry.
- **Flush pulse:** `flush` is high in the same cycle as the mispredicted entry's `commit_valid`.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles, release -> every output 0, `rob_count`=0.
- **Single instruction:** allocate with `alloc_phy_wr_reg`=7, `reg_wb`=1 (tag 0); complete tag 0 at edge E -> `commit_valid[0]`=1, `commit_with_write[0]`=1, `commited_wr_register[0]`=7 in the cycle after E+1; `rob_count` returns to 0.
- **Out-of-order completion:** allocate tags 0–3; complete them in order 3,1,2,0 -> no commit until tag 0 completes, then tags 0–3 retire in order, at most MAX_NUM_OF_COMMITS per cycle.
- **Full / overflow:** allocate 15 entries with no completions -> `rob_full`=1 at count 15. Allocate 1 more -> count 16, `overflow_err`=0. Allocate 1 more -> dropped, `overflow_err`=1, count stays 16.
- **Mispredict flush:** allocate tags 0–4; complete all, with tag 1 mispredicted and target 0x200 -> tags 0,1 retire; `flush`=1 and `flush_pc`=0x200 for one cycle; tags 2–4 never commit; count=0; the next allocation receives tag 2 (the new head).
- **Wrap-around:** stream 40 allocations, each completed 3 cycles later -> 40 commits in order with the correct `phy_reg` per entry, no drops, `overflow_err`=0 after pointers wrap twice.
